// File: rtl/pll_loop_filter.sv
// Digital PI loop filter for the PLL: turns signed phase-error samples into a
// DCO control word, with lock detection and clamp (saturation) reporting.
module pll_loop_filter #(
  parameter int ERR_W     = 16,
  parameter int DCO_W     = 12,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 32,
  parameter int LOCK_TOL  = 4,
  parameter int LOCK_CNT  = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [15:0]             kp_reg,
  input  logic [15:0]             ki_reg,
  input  logic [7:0]              n_reg,
  input  logic                    pll_enable,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] err,
  output logic [DCO_W-1:0]        dco_ctrl,
  output logic                    ctrl_valid,
  output logic                    locked,
  output logic                    sat
);

  localparam int PROD_W = ERR_W + 17;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;
  localparam int Y_W    = DCO_W + FRAC_BITS;
  localparam int CNT_W  = $clog2(LOCK_CNT + 1);
  localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W-Y_W){1'b0}}, {Y_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, INIT, TRACK, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [15:0]               kp_sh_q, kp_sh_d;
  logic [15:0]               ki_sh_q, ki_sh_d;
  logic signed [ACC_W-1:0]   integ_q, integ_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]  p_q, p_d;
  logic signed [PROD_W-1:0]  i_q, i_d;
  logic [DCO_W-1:0]          dco_q, dco_d;
  logic                      ctrl_valid_q, ctrl_valid_d;
  logic                      locked_q, locked_d;
  logic                      sat_q, sat_d;

  logic signed [ERR_W:0]     err_ext;
  logic [ERR_W:0]            abs_err;
  logic                      in_tol;
  logic signed [SUM_W-1:0]   sum1, sum2, integ_new, y_new;
  logic                      clamp1, clamp2;

  // Stage-1 math, lock tolerance and stage-2 clamping are all pure functions
  // of the current inputs/registers; the FSM below decides what gets stored.
  always_comb begin
    err_ext = {err[ERR_W-1], err};
    abs_err = err_ext[ERR_W] ? $unsigned(-err_ext) : $unsigned(err_ext);
    in_tol  = (abs_err <= (ERR_W+1)'(LOCK_TOL));

    p_d = $signed({{(PROD_W-ERR_W){err[ERR_W-1]}}, err}) *
          $signed({{(PROD_W-16){1'b0}}, kp_sh_q});
    i_d = $signed({{(PROD_W-ERR_W){err[ERR_W-1]}}, err}) *
          $signed({{(PROD_W-16){1'b0}}, ki_sh_q});

    sum1   = $signed({{(SUM_W-ACC_W){integ_q[ACC_W-1]}}, integ_q}) +
             $signed({{(SUM_W-PROD_W){i_q[PROD_W-1]}}, i_q});
    clamp1 = (sum1 < 0) || (sum1 > Y_MAX);
    integ_new = (sum1 < 0) ? '0 : ((sum1 > Y_MAX) ? Y_MAX : sum1);

    sum2   = integ_new + $signed({{(SUM_W-PROD_W){p_q[PROD_W-1]}}, p_q});
    clamp2 = (sum2 < 0) || (sum2 > Y_MAX);
    y_new  = (sum2 < 0) ? '0 : ((sum2 > Y_MAX) ? Y_MAX : sum2);
  end

  always_comb begin
    state_d      = state_q;
    kp_sh_d      = kp_sh_q;
    ki_sh_d      = ki_sh_q;
    integ_d      = integ_q;
    cnt_d        = cnt_q;
    s1_valid_d   = 1'b0;
    dco_d        = dco_q;
    ctrl_valid_d = 1'b0;
    locked_d     = locked_q;
    sat_d        = sat_q;

    case (state_q)
      IDLE: begin
        integ_d  = '0;
        cnt_d    = '0;
        dco_d    = '0;
        locked_d = 1'b0;
        sat_d    = 1'b0;
        if (pll_enable) state_d = INIT;
      end
      INIT: begin
        kp_sh_d  = kp_reg;
        ki_sh_d  = ki_reg;
        integ_d  = ACC_W'(n_reg) << (DCO_W - 8 + FRAC_BITS);
        dco_d    = DCO_W'(n_reg) << (DCO_W - 8);
        cnt_d    = '0;
        locked_d = 1'b0;
        sat_d    = 1'b0;
        state_d  = TRACK;
      end
      default: begin
        s1_valid_d = err_valid;
        if (err_valid) begin
          if (!in_tol) cnt_d = '0;
          else if (cnt_q != CNT_W'(LOCK_CNT)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (s1_valid_q) begin
          integ_d      = ACC_W'(integ_new);
          dco_d        = DCO_W'(y_new >>> FRAC_BITS);
          sat_d        = clamp1 || clamp2;
          ctrl_valid_d = 1'b1;
        end
        // Lock is flagged on the same edge the counter reaches its target.
        if (state_q == TRACK && cnt_d == CNT_W'(LOCK_CNT)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end else if (state_q == LOCKED && err_valid && !in_tol) begin
          state_d  = TRACK;
          locked_d = 1'b0;
        end
      end
    endcase

    if (!pll_enable) begin
      state_d      = IDLE;
      integ_d      = '0;
      cnt_d        = '0;
      s1_valid_d   = 1'b0;
      dco_d        = '0;
      ctrl_valid_d = 1'b0;
      locked_d     = 1'b0;
      sat_d        = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      kp_sh_q      <= '0;
      ki_sh_q      <= '0;
      integ_q      <= '0;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      p_q          <= '0;
      i_q          <= '0;
      dco_q        <= '0;
      ctrl_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      kp_sh_q      <= kp_sh_d;
      ki_sh_q      <= ki_sh_d;
      integ_q      <= integ_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      p_q          <= p_d;
      i_q          <= i_d;
      dco_q        <= dco_d;
      ctrl_valid_q <= ctrl_valid_d;
      locked_q     <= locked_d;
      sat_q        <= sat_d;
    end
  end

  assign dco_ctrl   = dco_q;
  assign ctrl_valid = ctrl_valid_q;
  assign locked     = locked_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed testbench for pll_loop_filter: seed, P and I paths, clamping,
// lock/unlock, disable flush and shadow-gain behaviour.
`timescale 1ns/1ps
module tb_pll_loop_filter;

  logic               HCLK = 1'b0;
  logic               HRESETn = 1'b0;
  logic [15:0]        kp_reg = '0;
  logic [15:0]        ki_reg = '0;
  logic [7:0]         n_reg = '0;
  logic               pll_enable = 1'b0;
  logic               err_valid = 1'b0;
  logic signed [15:0] err = '0;
  logic [11:0]        dco_ctrl;
  logic               ctrl_valid;
  logic               locked;
  logic               sat;

  int errors = 0;
  int checks = 0;

  pll_loop_filter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .kp_reg(kp_reg), .ki_reg(ki_reg), .n_reg(n_reg),
    .pll_enable(pll_enable), .err_valid(err_valid), .err(err),
    .dco_ctrl(dco_ctrl), .ctrl_valid(ctrl_valid), .locked(locked), .sat(sat)
  );

  always #5 HCLK = ~HCLK;

  // Advance n clock edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic signed [15:0] e);
    err_valid = v;
    err       = e;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic enableLoop(input logic [15:0] kp, input logic [15:0] ki,
                            input logic [7:0] n, input int expSeed);
    pll_enable = 1'b0;
    applyStimulus(1'b0, 16'sd0);
    tick(1);
    kp_reg = kp;
    ki_reg = ki;
    n_reg  = n;
    pll_enable = 1'b1;
    tick(1);
    checkOutput("init_no_valid_a", 32'(ctrl_valid), 0);
    tick(1);
    checkOutput("init_seed", 32'(dco_ctrl), expSeed);
    checkOutput("init_no_valid_b", 32'(ctrl_valid), 0);
    checkOutput("init_locked", 32'(locked), 0);
  endtask

  // One isolated sample: output must appear exactly two edges later.
  task automatic sendSample(input string tag, input logic signed [15:0] e,
                            input int expDco, input int expSat);
    applyStimulus(1'b1, e);
    tick(1);
    applyStimulus(1'b0, 16'sd0);
    checkOutput({tag, "_early"}, 32'(ctrl_valid), 0);
    tick(1);
    checkOutput({tag, "_valid"}, 32'(ctrl_valid), 1);
    checkOutput({tag, "_dco"}, 32'(dco_ctrl), expDco);
    checkOutput({tag, "_sat"}, 32'(sat), expSat);
    tick(1);
    checkOutput({tag, "_pulse"}, 32'(ctrl_valid), 0);
    checkOutput({tag, "_hold"}, 32'(dco_ctrl), expDco);
  endtask

  initial begin
    #12;
    checkOutput("rst_dco", 32'(dco_ctrl), 0);
    checkOutput("rst_valid", 32'(ctrl_valid), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_sat", 32'(sat), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick(1);

    applyStimulus(1'b1, 16'sd100);
    tick(3);
    checkOutput("idle_ignore_valid", 32'(ctrl_valid), 0);
    checkOutput("idle_ignore_dco", 32'(dco_ctrl), 0);

    enableLoop(16'd0, 16'd0, 8'd100, 1600);

    enableLoop(16'd256, 16'd0, 8'd100, 1600);
    sendSample("p_pos", 16'sd10, 1610, 0);
    sendSample("p_neg", -16'sd10, 1590, 0);
    sendSample("p_zero", 16'sd0, 1600, 0);

    enableLoop(16'd0, 16'd256, 8'd100, 1600);
    applyStimulus(1'b1, 16'sd1);
    tick(1);
    applyStimulus(1'b1, 16'sd1);
    tick(1);
    checkOutput("i_v1", 32'(ctrl_valid), 1);
    checkOutput("i_d1", 32'(dco_ctrl), 1601);
    applyStimulus(1'b1, 16'sd1);
    tick(1);
    checkOutput("i_v2", 32'(ctrl_valid), 1);
    checkOutput("i_d2", 32'(dco_ctrl), 1602);
    applyStimulus(1'b0, 16'sd0);
    tick(1);
    checkOutput("i_v3", 32'(ctrl_valid), 1);
    checkOutput("i_d3", 32'(dco_ctrl), 1603);
    tick(1);
    checkOutput("i_v_end", 32'(ctrl_valid), 0);
    sendSample("i_zero", 16'sd0, 1603, 0);

    enableLoop(16'hFFFF, 16'hFFFF, 8'd255, 4080);
    sendSample("sat_hi", 16'sd32767, 4095, 1);
    sendSample("sat_lo", 16'sh8000, 0, 1);
    sendSample("sat_clear", 16'sd0, 0, 0);

    enableLoop(16'd0, 16'd0, 8'd100, 1600);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 16'((i % 9) - 4));
      tick(1);
      checkOutput("lock_run15", 32'(locked), 0);
    end
    applyStimulus(1'b1, 16'sd5);
    tick(1);
    checkOutput("lock_break", 32'(locked), 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'(4 - (i % 9)));
      tick(1);
      checkOutput("lock_run16", 32'(locked), (i == 15) ? 1 : 0);
    end
    applyStimulus(1'b1, -16'sd4);
    tick(1);
    checkOutput("lock_stay", 32'(locked), 1);
    applyStimulus(1'b1, 16'sd5);
    tick(1);
    checkOutput("lock_drop", 32'(locked), 0);
    applyStimulus(1'b0, 16'sd0);
    tick(2);

    enableLoop(16'd256, 16'd0, 8'd100, 1600);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'sd0);
      tick(1);
    end
    checkOutput("dis_locked_before", 32'(locked), 1);
    applyStimulus(1'b1, 16'sd2);
    tick(1);
    checkOutput("dis_dco_before", 32'(dco_ctrl), 1600);
    pll_enable = 1'b0;
    applyStimulus(1'b0, 16'sd0);
    tick(1);
    checkOutput("dis_valid", 32'(ctrl_valid), 0);
    checkOutput("dis_dco", 32'(dco_ctrl), 0);
    checkOutput("dis_locked", 32'(locked), 0);
    tick(1);
    checkOutput("dis_valid_late", 32'(ctrl_valid), 0);

    enableLoop(16'd256, 16'd0, 8'd100, 1600);
    kp_reg = 16'd512;
    sendSample("gain_ignored", 16'sd10, 1610, 0);
    enableLoop(16'd512, 16'd0, 8'd100, 1600);
    sendSample("gain_applied", 16'sd10, 1620, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
